multi_sync_debounce: RTL and testbench



---
 rtl/sync_pkg.sv | 14 +
 rtl/sync_debounce_ch.sv | 59 +++++
 rtl/multi_sync_debounce.sv | 43 ++++
 tb/tb_multi_sync_debounce.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared defaults and helpers for input synchronizer/debounce blocks
package sync_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEBOUNCE_DEF    = 16;

    // Counter width able to hold 0..n, never narrower than one bit
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// rtl/sync_debounce_ch.sv - one channel: sync chain, debounce counter, edge pulses
module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int   STAGES          = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic          s;
    logic [CW-1:0] cnt;

    assign s = sync_q[STAGES-1];

    // Shift the raw pin through the metastability chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], raw};
        end
    end

    // Accept a new level only after it has disagreed with the current one for
    // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= RESET_VAL;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= ~s;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/multi_sync_debounce.sv
// rtl/multi_sync_debounce.sv - WIDTH independent synchronized, debounced inputs
module multi_sync_debounce
    import sync_pkg::*;
#(
    parameter int   WIDTH           = 4,
    parameter int   STAGES          = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] indata,
    output logic [WIDTH-1:0] outdata,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (WIDTH < 1) begin : g_bad_width
        $error("multi_sync_debounce: WIDTH must be >= 1");
    end
    if (STAGES < 2) begin : g_bad_stages
        $error("multi_sync_debounce: STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("multi_sync_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_debounce_ch #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (indata[i]),
            .level (outdata[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_multi_sync_debounce.sv
// tb/tb_multi_sync_debounce.sv - self-checking bench for multi_sync_debounce
module tb_multi_sync_debounce;

    localparam int STG = 2;

    logic       clk;
    logic       rst;
    logic [3:0] indata;
    logic [3:0] outdata, rise, fall;
    logic [3:0] outdata1, rise1, fall1;

    int checks;
    int errors;
    bit armed;
    bit counting;
    int r1cnt, f1cnt;

    multi_sync_debounce #(
        .WIDTH(4), .STAGES(STG), .DEBOUNCE_CYCLES(4), .RESET_VAL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .indata(indata),
        .outdata(outdata), .rise(rise), .fall(fall)
    );

    multi_sync_debounce #(
        .WIDTH(4), .STAGES(STG), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .indata(indata),
        .outdata(outdata1), .rise(rise1), .fall(fall1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: indata history since reset release; a channel's level flips on
    // edge n when the synced value seen on each of the last dc edges differed
    // from the level.
    logic [3:0] hist[$];
    int         n;
    logic [3:0] m_out  [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    int         dc;
    bit         flip;

    function automatic logic s_used(input int j, input int ch);
        int idx;
        idx = j - STG;
        if (idx < 1) return 1'b0;
        return hist[idx-1][ch];
    endfunction

    initial begin
        n = 0;
        for (int m = 0; m < 2; m++) begin
            m_out[m] = '0; m_rise[m] = '0; m_fall[m] = '0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                hist.delete();
                n = 0;
                for (int m = 0; m < 2; m++) begin
                    m_out[m] = '0; m_rise[m] = '0; m_fall[m] = '0;
                end
            end else begin
                hist.push_back(indata);
                n++;
                for (int m = 0; m < 2; m++) begin
                    dc = (m == 0) ? 4 : 1;
                    for (int ch = 0; ch < 4; ch++) begin
                        flip = (n >= dc);
                        for (int k = 0; k < dc; k++)
                            if (flip && s_used(n - k, ch) == m_out[m][ch]) flip = 1'b0;
                        m_rise[m][ch] = flip & ~m_out[m][ch];
                        m_fall[m][ch] = flip & m_out[m][ch];
                        if (flip) m_out[m][ch] = ~m_out[m][ch];
                    end
                end
            end
        end
    end

    // Compare both DUTs against the model on every falling edge
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if ({outdata, rise, fall, outdata1, rise1, fall1} !==
                {m_out[0], m_rise[0], m_fall[0], m_out[1], m_rise[1], m_fall[1]}) begin
                errors++;
                $display("FAIL model_cmp t=%0t got out=%h rise=%h fall=%h out1=%h rise1=%h fall1=%h exp out=%h rise=%h fall=%h out1=%h rise1=%h fall1=%h",
                         $time, outdata, rise, fall, outdata1, rise1, fall1,
                         m_out[0], m_rise[0], m_fall[0], m_out[1], m_rise[1], m_fall[1]);
            end
        end
    end

    always @(negedge clk) begin
        if (counting) begin
            r1cnt += int'(rise1[0]);
            f1cnt += int'(fall1[0]);
        end
    end

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    logic [3:0] saw;

    initial begin
        checks = 0; errors = 0; armed = 1'b0; counting = 1'b0;
        r1cnt = 0; f1cnt = 0;
        rst = 1'b1;
        indata = 4'hF;
        step(3);
        armed = 1'b1;
        chk("rst_out", outdata, 4'h0);
        chk("rst_pulse", rise | fall, 4'h0);
        rst = 1'b0;

        // Reset release with all inputs high
        step(5);
        chk("rel_pre_out", outdata, 4'h0);
        step(1);
        chk("rel_out", outdata, 4'hF);
        chk("rel_rise", rise, 4'hF);
        step(1);
        chk("rel_rise_clr", rise, 4'h0);

        // Settle with only channel 2 high
        indata = 4'b0100;
        step(10);

        // Channel 0 rising
        indata = 4'b0101;
        step(2);
        chk("c0_d1_pre", outdata1, 4'b0100);
        step(1);
        chk("c0_d1_out", outdata1, 4'b0101);
        chk("c0_d1_rise", rise1, 4'b0001);
        step(2);
        chk("c0_pre", outdata, 4'b0100);
        step(1);
        chk("c0_out", outdata, 4'b0101);
        chk("c0_rise", rise, 4'b0001);
        step(1);
        chk("c0_rise_clr", rise, 4'b0000);
        step(4);

        // Channel 1 glitch of 3 cycles is rejected
        indata = 4'b0111;
        step(3);
        indata = 4'b0101;
        saw = '0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            saw = saw | (rise & 4'b0010) | (fall & 4'b0010) | (outdata & 4'b0010);
        end
        chk("glitch3", saw, 4'b0000);

        // A 4-cycle pulse is accepted, then released
        indata = 4'b0111;
        step(4);
        indata = 4'b0101;
        step(2);
        chk("glitch4_out", outdata, 4'b0111);
        chk("glitch4_rise", rise, 4'b0010);
        step(4);
        chk("glitch4_fall", fall, 4'b0010);
        chk("glitch4_back", outdata, 4'b0101);
        step(4);

        // Channel 2 falling
        indata = 4'b0001;
        step(5);
        chk("c2_pre", outdata, 4'b0101);
        step(1);
        chk("c2_out", outdata, 4'b0001);
        chk("c2_fall", fall, 4'b0100);
        step(1);
        chk("c2_fall_clr", fall, 4'b0000);
        step(4);

        // Reset in the middle of channel 3's count
        indata = 4'b1001;
        step(4);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out", outdata, 4'h0);
        chk("midrst_pulse", rise | fall, 4'h0);
        step(2);
        rst = 1'b0;
        step(5);
        chk("midrst_pre", outdata, 4'h0);
        step(1);
        chk("midrst_out2", outdata, 4'b1001);
        chk("midrst_rise", rise, 4'b1001);
        step(4);

        // Alternating 4-cycle pattern on channel 0
        indata = 4'b0000;
        step(10);
        counting = 1'b1;
        for (int i = 0; i < 2; i++) begin
            indata = 4'b0001;
            step(4);
            indata = 4'b0000;
            step(4);
        end
        step(6);
        counting = 1'b0;
        chk_int("d1_rises", r1cnt, 2);
        chk_int("d1_falls", f1cnt, 2);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
